// File: rtl/serial_rx.sv
// ----------------------------------------------------------------------------
// serial_rx
// UART-style 8N1 receiver, LSB first, fixed CLK_PER_BIT clocks per bit.
// Receive end of the link driven by serial_tx. Each correctly framed byte is
// presented on data with a one-cycle new_data strobe; a low stop bit gives a
// one-cycle frame_err strobe and leaves data untouched.
//
// Ports:
//   clk        in   1  system clock, all logic on posedge
//   rst        in   1  synchronous, active-high reset
//   rx         in   1  serial line, idles high, asynchronous to clk
//   data       out  8  last correctly framed byte, held until the next one
//   new_data   out  1  one-cycle strobe, data valid in the same cycle
//   frame_err  out  1  one-cycle strobe, stop bit sampled low
// ----------------------------------------------------------------------------
module serial_rx #(
   parameter int CLK_PER_BIT = 50,
   parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       new_data,
   output logic       frame_err
);

   localparam int HALF = CLK_PER_BIT / 2;
   localparam logic [CTR_SIZE-1:0] C_HALF_M1 = CTR_SIZE'(HALF - 1);
   localparam logic [CTR_SIZE-1:0] C_FULL_M1 = CTR_SIZE'(CLK_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_HIGH = 3'd4
   } state_t;

   state_t                r_state;
   logic                  r_sync1;
   logic                  r_sync2;
   logic [CTR_SIZE-1:0]   r_ctr;
   logic [2:0]            r_bit_ctr;
   logic [7:0]            r_shift;
   logic [7:0]            r_data;
   logic                  r_new_data;
   logic                  r_frame_err;
   logic                  w_rx_s;

   // Every decision is taken on the synchronized line only.
   assign w_rx_s    = r_sync2;
   assign data      = r_data;
   assign new_data  = r_new_data;
   assign frame_err = r_frame_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_ctr       <= '0;
         r_bit_ctr   <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_new_data  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_sync1     <= rx;
         r_sync2     <= r_sync1;
         // Strobes default low so each lasts exactly one cycle.
         r_new_data  <= 1'b0;
         r_frame_err <= 1'b0;

         case (r_state)
            S_IDLE: begin
               r_ctr     <= '0;
               r_bit_ctr <= '0;
               if (!w_rx_s) r_state <= S_START;
            end

            // Wait half a bit, then confirm the start bit is still low so a
            // short glitch does not launch a frame.
            S_START: begin
               if (r_ctr == C_HALF_M1) begin
                  r_ctr <= '0;
                  if (w_rx_s) r_state <= S_IDLE;
                  else        r_state <= S_DATA;
               end else begin
                  r_ctr <= r_ctr + CTR_SIZE'(1);
               end
            end

            // From the start-bit centre, every full bit period lands on the
            // centre of the next data bit.
            S_DATA: begin
               if (r_ctr == C_FULL_M1) begin
                  r_ctr              <= '0;
                  r_shift[r_bit_ctr] <= w_rx_s;
                  r_bit_ctr          <= r_bit_ctr + 3'd1;
                  if (r_bit_ctr == 3'd7) r_state <= S_STOP;
               end else begin
                  r_ctr <= r_ctr + CTR_SIZE'(1);
               end
            end

            // Returning to IDLE mid-stop-bit lets a back-to-back start edge
            // be caught with no idle gap.
            S_STOP: begin
               if (r_ctr == C_FULL_M1) begin
                  r_ctr <= '0;
                  if (w_rx_s) begin
                     r_data     <= r_shift;
                     r_new_data <= 1'b1;
                     r_state    <= S_IDLE;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= S_WAIT_HIGH;
                  end
               end else begin
                  r_ctr <= r_ctr + CTR_SIZE'(1);
               end
            end

            // Break / line fault: a held-low line must not be taken as a
            // string of start bits.
            S_WAIT_HIGH: begin
               r_ctr     <= '0;
               r_bit_ctr <= '0;
               if (w_rx_s) r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
